// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle load/store core: sequencer states,
// opcodes and instruction field extraction.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } cpu_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  // Helpers operate on a zero-extended instruction word; callers narrow the result.
  localparam int unsigned FIELD_W = 32;

  function automatic logic [FIELD_W-1:0] f_mask(input int unsigned raw);
    return (FIELD_W'(1) << raw) - FIELD_W'(1);
  endfunction

  function automatic logic [1:0] f_op(input logic [FIELD_W-1:0] ir, input int unsigned raw);
    logic [FIELD_W-1:0] t;
    t = ir >> (3 * raw);
    return t[1:0];
  endfunction

  function automatic logic [FIELD_W-1:0] f_rs(input logic [FIELD_W-1:0] ir, input int unsigned raw);
    return (ir >> (2 * raw)) & f_mask(raw);
  endfunction

  function automatic logic [FIELD_W-1:0] f_rt(input logic [FIELD_W-1:0] ir, input int unsigned raw);
    return (ir >> raw) & f_mask(raw);
  endfunction

  function automatic logic [FIELD_W-1:0] f_rd(input logic [FIELD_W-1:0] ir, input int unsigned raw);
    return ir & f_mask(raw);
  endfunction

  function automatic logic [FIELD_W-1:0] f_simm(input logic [FIELD_W-1:0] ir, input int unsigned raw);
    logic [FIELD_W-1:0] v;
    logic [FIELD_W-1:0] t;
    v = ir & f_mask(raw);
    t = ir >> (raw - 1);
    if (t[0]) v = v | ~f_mask(raw);
    return v;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// optional hard-wired zero register.
module cpu_regfile #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned REG_ADDR_W = 2,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = ((ZERO_REG != 0) && (raddr_a == '0)) ? '0 : regs[raddr_a];
  assign rdata_b = ((ZERO_REG != 0) && (raddr_b == '0)) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle load/store core with req/ack instruction and data ports,
// single-step control, retire counter and write-back debug strobe.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned REG_ADDR_W = 2,
  parameter  int unsigned PC_W       = 8,
  parameter  int unsigned CNT_W      = 16,
  parameter  int unsigned ZERO_REG   = 0,
  localparam int unsigned INSTR_W    = 2 + 3 * REG_ADDR_W
) (
  input  logic                  Clk_O,
  input  logic                  Reset,
  input  logic                  run_en,
  input  logic                  step_mode,
  input  logic                  step,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_W-1:0]    imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic [PC_W-1:0]       pc,
  output logic [2:0]            state,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic [CNT_W-1:0]      retired
);

  cpu_state_e state_q, state_d;

  logic [INSTR_W-1:0]    ir_q;
  logic [DATA_W-1:0]     a_q, b_q, rd_a, rd_b;
  logic [1:0]            op;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     simm_d, alu_sum, eff_addr;
  logic [PC_W-1:0]       simm_p, pc_inc, br_target, pc_d;
  logic                  retire;

  assign op     = f_op(FIELD_W'(ir_q), REG_ADDR_W);
  assign rs     = REG_ADDR_W'(f_rs(FIELD_W'(ir_q), REG_ADDR_W));
  assign rt     = REG_ADDR_W'(f_rt(FIELD_W'(ir_q), REG_ADDR_W));
  assign rd     = REG_ADDR_W'(f_rd(FIELD_W'(ir_q), REG_ADDR_W));
  assign simm_d = DATA_W'(f_simm(FIELD_W'(ir_q), REG_ADDR_W));
  assign simm_p = PC_W'(f_simm(FIELD_W'(ir_q), REG_ADDR_W));

  assign alu_sum   = a_q + b_q;
  assign eff_addr  = a_q + simm_d;
  assign pc_inc    = pc + PC_W'(1);
  assign br_target = pc_inc + simm_p;

  assign imem_addr = pc;
  assign state     = state_q;

  cpu_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_regfile (
    .clk     (Clk_O),
    .rst     (Reset),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .we      (state_q == S_WB),
    .waddr   (wb_reg),
    .wdata   (wb_data)
  );

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer next state plus pc update and retire decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run_en && (!step_mode || step)) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD:       state_d = S_WB;
          OP_LD, OP_ST: state_d = S_MEM;
          default: begin
            state_d = S_IDLE;
            pc_d    = (a_q == b_q) ? br_target : pc_inc;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_LD) begin
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
            pc_d    = pc_inc;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        pc_d    = pc_inc;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered port outputs; request strobes follow the next state.
  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pc         <= '0;
      retired    <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
    end else begin
      imem_req <= (state_d == S_FETCH);
      dmem_req <= (state_d == S_MEM);
      dmem_we  <= (state_d == S_MEM) && (op == OP_ST);
      wb_valid <= (state_d == S_WB);
      pc       <= pc_d;
      if (retire) retired <= retired + CNT_W'(1);
      if ((state_q == S_FETCH) && imem_ack) ir_q <= imem_rdata;
      if (state_q == S_DECODE) begin
        a_q <= rd_a;
        b_q <= rd_b;
      end
      if ((state_q == S_EXEC) && ((op == OP_LD) || (op == OP_ST))) begin
        dmem_addr  <= eff_addr;
        dmem_wdata <= b_q;
      end
      if (state_d == S_WB) begin
        wb_reg  <= (op == OP_ADD) ? rd : rt;
        wb_data <= (state_q == S_EXEC) ? alu_sum : dmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: directed programs issued in step mode,
// monitors compare write-backs, data accesses and retirements against queues.
module tb_multicycle_cpu;

  logic       clk, Reset, run_en, step_mode, step;
  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, wb_valid;
  logic [7:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc, wb_data;
  logic [2:0] state;
  logic [1:0] wb_reg;
  logic [15:0] retired;

  multicycle_cpu #(
    .DATA_W(8), .REG_ADDR_W(2), .PC_W(8), .CNT_W(16), .ZERO_REG(0)
  ) dut (
    .Clk_O(clk), .Reset(Reset), .run_en(run_en), .step_mode(step_mode), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .state(state),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: ack arrives in the Nth cycle of a request (N=1 is zero-wait).
  logic [7:0]  imem [256];
  logic [7:0]  dmem [256];
  int unsigned dack_cycle;
  int unsigned icnt, dcnt;
  logic        ack_force, init_mem;

  assign imem_ack   = imem_req;
  assign dmem_ack   = (dmem_req && (dcnt + 1 >= dack_cycle)) || ack_force;
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (init_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
      dmem[8'h00] <= 8'h03;
      dmem[8'h01] <= 8'h04;
      dmem[8'hFF] <= 8'hF0;
      dmem[8'hFE] <= 8'h20;
      dmem[8'h10] <= 8'h05;
      dmem[8'h11] <= 8'h5A;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  typedef struct { logic [1:0] r; logic [7:0] d; } wb_t;
  typedef struct { logic [7:0] pc; logic [15:0] ret; } ret_t;
  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; int unsigned cyc; } dm_t;

  wb_t  wb_q[$];
  ret_t ret_q[$];
  dm_t  dm_q[$];

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_pc;
  logic [15:0] exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write-back, access or retirement.
  wb_t         mw;
  ret_t        mr;
  dm_t         md;
  logic [15:0] last_ret;
  int unsigned mon_dcnt;
  logic        wb_chk_next, d_chk_next;

  initial begin
    last_ret = '0; mon_dcnt = 0; wb_chk_next = 1'b0; d_chk_next = 1'b0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        last_ret = retired; mon_dcnt = 0; wb_chk_next = 1'b0; d_chk_next = 1'b0;
      end else begin
        if (wb_chk_next) begin
          chk("wb_valid_one_cycle", 32'(wb_valid), 32'd0);
          wb_chk_next = 1'b0;
        end
        if (wb_valid) begin
          if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
          else begin
            mw = wb_q.pop_front();
            chk("wb_reg", 32'(wb_reg), 32'(mw.r));
            chk("wb_data", 32'(wb_data), 32'(mw.d));
            wb_chk_next = 1'b1;
          end
        end
        if (retired != last_ret) begin
          if (ret_q.size() == 0) chk("retire_unexpected", 32'(retired), 32'(last_ret));
          else begin
            mr = ret_q.pop_front();
            chk("pc_after_retire", 32'(pc), 32'(mr.pc));
            chk("retired", 32'(retired), 32'(mr.ret));
          end
          last_ret = retired;
        end
        if (d_chk_next) begin
          chk("dmem_req_drop", 32'(dmem_req), 32'd0);
          d_chk_next = 1'b0;
        end
        if (dmem_req) begin
          mon_dcnt++;
          if (dmem_ack) begin
            if (dm_q.size() == 0) chk("dmem_unexpected", 32'd1, 32'd0);
            else begin
              md = dm_q.pop_front();
              chk("dmem_we", 32'(dmem_we), 32'(md.we));
              chk("dmem_addr", 32'(dmem_addr), 32'(md.addr));
              if (md.we) chk("dmem_wdata", 32'(dmem_wdata), 32'(md.wdata));
              chk("dmem_req_cycles", mon_dcnt, md.cyc);
            end
            d_chk_next = 1'b1;
            mon_dcnt = 0;
          end
        end else begin
          mon_dcnt = 0;
        end
      end
    end
  end

  task automatic push_wb(input logic [1:0] r, input logic [7:0] d);
    wb_t e; e.r = r; e.d = d; wb_q.push_back(e);
  endtask

  task automatic push_dm(input logic we, input logic [7:0] addr, input logic [7:0] wd, input int unsigned cyc);
    dm_t e; e.we = we; e.addr = addr; e.wdata = wd; e.cyc = cyc; dm_q.push_back(e);
  endtask

  task automatic push_ret(input logic [7:0] next_pc);
    ret_t e;
    exp_ret = exp_ret + 16'd1;
    e.pc = next_pc; e.ret = exp_ret; ret_q.push_back(e);
    exp_pc = next_pc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state != 3'd0 && n < 200) begin @(negedge clk); n++; end
    if (state != 3'd0) chk("idle_timeout", 32'(state), 32'd0);
  endtask

  // Place instr at the expected pc, issue it with one step pulse, check IDLE-to-IDLE latency.
  task automatic issue(input logic [7:0] instr, input int unsigned exp_lat, input logic [7:0] next_pc);
    int unsigned n;
    imem[exp_pc] = instr;
    push_ret(next_pc);
    wait_idle();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n = 0;
    while (state != 3'd0 && n < 200) begin @(negedge clk); n++; end
    chk("latency", n + 1, exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; run_en = 1'b0; step_mode = 1'b1; step = 1'b0;
    ack_force = 1'b0; init_mem = 1'b1; dack_cycle = 1;
    exp_pc = 8'h00; exp_ret = 16'd0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    repeat (3) @(negedge clk);
    #2 Reset = 1'b0; init_mem = 1'b0;
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_bus", {16'd0, wb_data, 6'd0, wb_reg}, 32'd0);
    chk("rst_dmem_bus", {16'd0, dmem_addr, dmem_wdata}, 32'd0);
    run_en = 1'b1;

    // Preload r1=3, r2=4, add; then r1=0xF0, r2=0x20 overflow add.
    push_dm(1'b0, 8'h00, 8'h00, 1); push_wb(2'd1, 8'h03); issue(8'h44, 6, 8'h01);
    push_dm(1'b0, 8'h01, 8'h00, 1); push_wb(2'd2, 8'h04); issue(8'h49, 6, 8'h02);
    push_wb(2'd3, 8'h07); issue(8'h1B, 5, 8'h03);
    push_dm(1'b0, 8'hFF, 8'h00, 1); push_wb(2'd1, 8'hF0); issue(8'h47, 6, 8'h04);
    push_dm(1'b0, 8'hFE, 8'h00, 1); push_wb(2'd2, 8'h20); issue(8'h4A, 6, 8'h05);
    push_wb(2'd3, 8'h10); issue(8'h1B, 5, 8'h06);
    push_dm(1'b0, 8'h10, 8'h00, 1); push_wb(2'd1, 8'h05); issue(8'h74, 6, 8'h07);
    push_dm(1'b0, 8'h11, 8'h00, 1); push_wb(2'd2, 8'h5A); issue(8'h79, 6, 8'h08);

    // Slow data memory: ST r2 -> [r1-1], then LD r3 <- [r1-1].
    dack_cycle = 3;
    push_dm(1'b1, 8'h04, 8'h5A, 3); issue(8'h9B, 7, 8'h09);
    push_dm(1'b0, 8'h04, 8'h00, 3); push_wb(2'd3, 8'h5A); issue(8'h5F, 8, 8'h0A);
    dack_cycle = 1;

    for (int i = 0; i < 6; i++) begin
      push_wb(2'd0, 8'h00); issue(8'h00, 5, exp_pc + 8'h01);
    end
    issue(8'hC2, 4, 8'h0F);
    push_wb(2'd0, 8'h00); issue(8'h00, 5, 8'h10);
    issue(8'hDA, 4, 8'h11);
    push_dm(1'b1, 8'h04, 8'h5A, 1); issue(8'h9B, 5, 8'h12);

    // Step mode without a step pulse holds; one pulse retires exactly one instruction.
    repeat (20) @(negedge clk);
    chk("hold_pc", 32'(pc), 32'h12);
    chk("hold_state", 32'(state), 32'd0);
    chk("hold_retired", 32'(retired), 32'(exp_ret));
    push_wb(2'd3, 8'h5F); issue(8'h1B, 5, 8'h13);
    repeat (10) @(negedge clk);
    chk("single_step_retired", 32'(retired), 32'(exp_ret));
    chk("single_step_pc", 32'(pc), 32'h13);

    // Reset during a stalled load; late ack afterwards must be ignored.
    dack_cycle = 1000;
    imem[exp_pc] = 8'h5F;
    wait_idle();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int n = 0; n < 20 && !dmem_req; n++) @(negedge clk);
    chk("reached_mem", 32'(dmem_req), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("abort_dmem_req", 32'(dmem_req), 32'd0);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    repeat (2) @(negedge clk);
    #2 Reset = 1'b0;
    exp_pc = 8'h00; exp_ret = 16'd0;
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    dack_cycle = 1;
    chk("late_ack_state", 32'(state), 32'd0);
    chk("late_ack_pc", 32'(pc), 32'd0);
    chk("late_ack_retired", 32'(retired), 32'd0);

    // Registers cleared; backward branch from 0 wraps, then pc wraps 0xFF -> 0x00.
    issue(8'hC2, 4, 8'hFF);
    push_wb(2'd0, 8'h00); issue(8'h30, 5, 8'h00);
    push_wb(2'd3, 8'h00); issue(8'h1B, 5, 8'h01);

    // Free-run with run_en dropped during fetch: instruction completes, core stops.
    step_mode = 1'b0;
    imem[exp_pc] = 8'h1B;
    push_wb(2'd3, 8'h00); push_ret(8'h02);
    run_en = 1'b1;
    @(negedge clk);
    run_en = 1'b0;
    repeat (15) @(negedge clk);
    chk("run_stop_pc", 32'(pc), 32'h02);
    chk("run_stop_state", 32'(state), 32'd0);
    chk("run_stop_retired", 32'(retired), 32'd4);

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("ret_queue_drained", 32'(ret_q.size()), 32'd0);
    chk("dmem_queue_drained", 32'(dm_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multi-cycle load/store CPU core: register file, ALU, branch unit and a 6-state sequencer.
- Fetches instructions and accesses data over separate req/ack memory ports, so instruction and data memories of any latency can be attached.
- Adds conditional branch, single-step mode, a retire counter and a write-back debug port for 7-segment display logic at the top level.

Parameters:
- DATA_W, 8, register/ALU/data-address width (>=4).
- REG_ADDR_W, 2, register index width; NUM_REGS = 2**REG_ADDR_W.
- PC_W, 8, program counter width.
- CNT_W, 16, retired-instruction counter width.
- ZERO_REG, 0, 1 = r0 reads as 0 and ignores writes.
- INSTR_W (localparam) = 2 + 3*REG_ADDR_W.

Ports:
- Clk_O  in  1  system clock, all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- run_en  in  1  permits instruction issue.
- step_mode  in  1  1 = issue one instruction per step pulse.
- step  in  1  single-step request, sampled in IDLE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  INSTR_W  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DATA_W  effective address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  access complete; load data valid.
- dmem_rdata  in  DATA_W  load data.
- pc  out  PC_W  current program counter.
- state  out  3  sequencer state (debug).
- wb_valid  out  1  one-cycle register-write strobe.
- wb_reg  out  REG_ADDR_W  written register.
- wb_data  out  DATA_W  written value.
- retired  out  CNT_W  retired instruction count, wraps.

Behaviour:
- Instruction fields:
  - op = [INSTR_W-1:INSTR_W-2]
  - rs = next REG_ADDR_W bits
  - rt = next REG_ADDR_W bits
  - rd/imm = low REG_ADDR_W bits
  - simm = sign-extended imm, to DATA_W (address use) or PC_W (branch use).
- Ops:
  - 00 ADD: rd = rs + rt, mod 2**DATA_W.
  - 01 LD: rt = mem[rs + simm].
  - 10 ST: mem[rs + simm] = rt.
  - 11 BEQ: if rs == rt then pc = pc + 1 + simm, else pc + 1; mod 2**PC_W.
- Reset (async):
  - state = IDLE; pc = 0; all registers = 0; retired = 0.
  - imem_req, dmem_req, dmem_we, wb_valid = 0; wb_reg, wb_data, dmem_addr, dmem_wdata = 0.
  - Any in-flight transaction is abandoned and req drops immediately.
  - A late ack arriving after reset is ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6–7 go to IDLE.
- IDLE:
  - Go to FETCH if run_en && (!step_mode || step).
  - A step held high issues one instruction per visit to IDLE; a pulse outside IDLE is ignored.
  - run_en low → remain in IDLE. Dropping run_en mid-instruction completes that instruction, then stops in IDLE.
- FETCH:
  - imem_req = 1; imem_addr held at pc.
  - On imem_ack (may arrive in the same cycle as req), latch IR and go to DECODE.
  - imem_req is 0 in the following cycle.
- DECODE: latch A = R[rs], B = R[rt]; go to EXEC.
- EXEC:
  - ADD: result = A + B → WB.
  - LD/ST: address = A + simm → MEM.
  - BEQ: update pc, retired += 1 → IDLE.
- MEM:
  - dmem_req = 1; dmem_we = (op == ST); dmem_addr and dmem_wdata = B held stable until ack.
  - On ack, LD latches dmem_rdata → WB.
  - On ack, ST does pc += 1, retired += 1 → IDLE.
  - dmem_req is 0 the cycle after ack.
- WB:
  - Write R[dest] (rd for ADD, rt for LD).
  - wb_valid = 1 for exactly this cycle, with wb_reg/wb_data. wb_reg/wb_data hold their last values afterwards.
  - pc += 1; retired += 1 → IDLE.
  - With ZERO_REG=1 and dest = 0: the strobe still fires, wb_data shows the computed value, and the register is not written.
- Zero-wait latency (ack in the same cycle as req), measured from IDLE:
  - ADD: 5 cycles.
  - LD: 6 cycles.
  - ST: 5 cycles.
  - BEQ: 4 cycles.
- Wrap-around:
  - pc wraps at 2**PC_W (0xFF → 0x00 at defaults).
  - A backward branch from pc = 0 wraps to the top of PC space.
  - retired wraps silently.
- Register reads are combinational from the register file and sampled in DECODE, so there are no hazards.

Decomposition:
- Package cpu_pkg: state encoding constants, opcode constants (OP_ADD, OP_LD, OP_ST, OP_BEQ), and field-extraction helper functions parametrised by REG_ADDR_W.
- Sub-module cpu_regfile: NUM_REGS x DATA_W, 2 async read ports, 1 synchronous write port, async reset, ZERO_REG option.
- Sequencer, ALU and pc logic stay in multicycle_cpu.

Test Plan:
- ADD: reset; preload r1=3, r2=4 via LD; fetch ADD r1,r2,r3 (0x1B) → wb_valid for 1 cycle, wb_reg=3, wb_data=0x07, retired +1, pc +1.
- Overflow: r1=0xF0, r2=0x20, ADD → wb_data=0x10.
- LD/ST with 3-cycle-delayed acks: ST r2→[r1-1] with r1=5, r2=0x5A → dmem_addr=0x04, we=1, wdata=0x5A, req held 3 cycles; LD rt←[r1-1] → wb_data=0x5A; zero-wait LD takes 6 cycles IDLE→IDLE.
- BEQ: equal regs, imm=-2 at pc=0x10 → pc=0x0F. Unequal → pc=0x11. At pc=0x00 with imm=-2, taken → pc=0xFF.
- Step mode: step_mode=1, run_en=1, no step → pc constant for 20 cycles. One step pulse → exactly one instruction retires, then IDLE.
- Reset mid-MEM (dmem_req=1) → req drops in the same cycle, pc=0, all registers 0; a subsequent ack causes no write and no state change.
